// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and port-index width helper for the N-way memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // A port index needs at least one bit even for a degenerate single-port build.
    function automatic int ptr_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_nway_rr_picker.sv
// rtl/mem_arbiter_nway_rr_picker.sv - first requester strictly after a round-robin pointer, wrapping
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        found = |req;
        idx   = '0;
        cand  = '0;
        // Scan from the farthest slot back to the nearest so the nearest requester wins.
        for (int k = N; k >= 1; k--) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_nway.sv
// rtl/mem_arbiter_nway.sv - N-port memory arbiter with two priority classes, RR within class, bounded burst lock
module mem_arbiter_nway
    import mem_arb_pkg::*;
#(
    parameter int                   NUM_PORTS  = 4,
    parameter int                   ADDR_W     = 19,
    parameter int                   DATA_W     = 16,
    parameter int                   BE_W       = 2,
    parameter logic [NUM_PORTS-1:0] HIPRI_MASK = NUM_PORTS'(4'b0100),
    parameter int                   MAX_BURST  = 8,
    localparam int                  PTR_W      = ptr_width(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS-1:0]        req_access,
    input  logic [NUM_PORTS-1:0]        req_wr_en,
    input  logic [NUM_PORTS*BE_W-1:0]   req_bytesel,
    input  logic [NUM_PORTS-1:0]        req_lock,
    output logic [NUM_PORTS-1:0]        rsp_ack,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           mem_m_addr,
    output logic [DATA_W-1:0]           mem_m_data_out,
    output logic                        mem_m_access,
    output logic                        mem_m_wr_en,
    output logic [BE_W-1:0]             mem_m_bytesel,
    input  logic [DATA_W-1:0]           mem_m_data_in,
    input  logic                        mem_m_ack,
    output logic                        grant_valid,
    output logic [PTR_W-1:0]            grant_id
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    arb_state_t           state;
    logic [PTR_W-1:0]     hi_ptr;
    logic [PTR_W-1:0]     lo_ptr;
    logic [PTR_W-1:0]     hi_idx;
    logic [PTR_W-1:0]     lo_idx;
    logic [PTR_W-1:0]     pick_id;
    logic                 hi_found;
    logic                 lo_found;
    logic                 pick_valid;
    logic [NUM_PORTS-1:0] hi_req;
    logic [NUM_PORTS-1:0] lo_req;
    logic [NUM_PORTS-1:0] owner_onehot;
    logic [7:0]           burst_cnt;
    logic                 owner_req;
    logic                 owner_hi;
    logic                 keep_burst;
    logic                 rearb;
    logic                 take_pick;
    logic                 go_idle;

    assign hi_req = req_access & HIPRI_MASK;
    assign lo_req = req_access & ~HIPRI_MASK;

    rr_picker #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_pick_hi (
        .req   (hi_req),
        .ptr   (hi_ptr),
        .found (hi_found),
        .idx   (hi_idx)
    );

    rr_picker #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_pick_lo (
        .req   (lo_req),
        .ptr   (lo_ptr),
        .found (lo_found),
        .idx   (lo_idx)
    );

    // The high class wins outright whenever any of its ports is asking.
    assign pick_valid   = hi_found | lo_found;
    assign pick_id      = hi_found ? hi_idx : lo_idx;

    assign owner_req    = req_access[grant_id];
    assign owner_hi     = HIPRI_MASK[grant_id];
    assign owner_onehot = NUM_PORTS'(1) << grant_id;

    assign keep_burst = req_lock[grant_id] && owner_req && (burst_cnt < BURST_LIMIT)
                        && !(hi_found && !owner_hi);

    // Re-arbitrate from idle, when the owner abandons its word, or at an ACK that ends the burst.
    always_comb begin
        rearb = 1'b0;
        case (state)
            IDLE:    rearb = 1'b1;
            SERVE:   rearb = !owner_req;
            ACK:     rearb = !keep_burst;
            default: rearb = 1'b1;
        endcase
        take_pick = rearb && pick_valid;
        go_idle   = rearb && !pick_valid;
    end

    always_comb begin
        mem_m_addr     = '0;
        mem_m_data_out = '0;
        mem_m_access   = 1'b0;
        mem_m_wr_en    = 1'b0;
        mem_m_bytesel  = '1;
        if (state == SERVE) begin
            mem_m_addr     = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            mem_m_data_out = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
            mem_m_access   = owner_req;
            mem_m_wr_en    = req_wr_en[grant_id];
            mem_m_bytesel  = req_bytesel[int'(grant_id)*BE_W +: BE_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rsp_ack     <= '0;
            rsp_rdata   <= '0;
            hi_ptr      <= PTR_W'(NUM_PORTS - 1);
            lo_ptr      <= PTR_W'(NUM_PORTS - 1);
            burst_cnt   <= '0;
        end else begin
            rsp_ack <= '0;

            if (rearb) begin
                burst_cnt <= '0;
            end

            if (take_pick) begin
                state       <= SERVE;
                grant_valid <= 1'b1;
                grant_id    <= pick_id;
                if (hi_found) begin
                    hi_ptr <= pick_id;
                end else begin
                    lo_ptr <= pick_id;
                end
            end else if (go_idle) begin
                state       <= IDLE;
                grant_valid <= 1'b0;
            end else begin
                case (state)
                    SERVE: begin
                        if (mem_m_ack) begin
                            state   <= ACK;
                            rsp_ack <= owner_onehot;
                            if (!req_wr_en[grant_id]) begin
                                rsp_rdata <= mem_m_data_in;
                            end
                            if (burst_cnt < BURST_LIMIT) begin
                                burst_cnt <= burst_cnt + 8'd1;
                            end
                        end
                    end
                    // Burst continuation keeps both RR pointers untouched.
                    ACK: begin
                        state <= SERVE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nway.sv
// tb/tb_mem_arbiter_nway.sv - self-checking bench for mem_arbiter_nway
module tb_mem_arbiter_nway;

    localparam int NP = 4;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int MB = 4;
    localparam logic [NP-1:0] HI = 4'b0100;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP-1:0]     req_access;
    logic [NP-1:0]     req_wr_en;
    logic [NP*BW-1:0]  req_bytesel;
    logic [NP-1:0]     req_lock;
    logic [NP-1:0]     rsp_ack;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     mem_m_addr;
    logic [DW-1:0]     mem_m_data_out;
    logic              mem_m_access;
    logic              mem_m_wr_en;
    logic [BW-1:0]     mem_m_bytesel;
    logic [DW-1:0]     mem_m_data_in;
    logic              mem_m_ack;
    logic              grant_valid;
    logic [1:0]        grant_id;

    logic [AW-1:0] a_addr  [NP];
    logic [DW-1:0] a_wdata [NP];
    logic [BW-1:0] a_bs    [NP];

    for (genvar p = 0; p < NP; p++) begin : g_pack
        assign req_addr[p*AW +: AW]    = a_addr[p];
        assign req_wdata[p*DW +: DW]   = a_wdata[p];
        assign req_bytesel[p*BW +: BW] = a_bs[p];
    end

    mem_arbiter_nway #(
        .NUM_PORTS  (NP),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .BE_W       (BW),
        .HIPRI_MASK (HI),
        .MAX_BURST  (MB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_access     (req_access),
        .req_wr_en      (req_wr_en),
        .req_bytesel    (req_bytesel),
        .req_lock       (req_lock),
        .rsp_ack        (rsp_ack),
        .rsp_rdata      (rsp_rdata),
        .mem_m_addr     (mem_m_addr),
        .mem_m_data_out (mem_m_data_out),
        .mem_m_access   (mem_m_access),
        .mem_m_wr_en    (mem_m_wr_en),
        .mem_m_bytesel  (mem_m_bytesel),
        .mem_m_data_in  (mem_m_data_in),
        .mem_m_ack      (mem_m_ack),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 = none), per-class pointers, words in current burst.
    int m_owner;
    int m_hp;
    int m_lp;
    int m_burst;
    int m_cnt;
    bit m_in_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
        return DW'(a) ^ 16'h3C5A;
    endfunction

    task automatic do_reset();
        reset_n       = 1'b0;
        req_access    = '0;
        req_lock      = '0;
        req_wr_en     = '0;
        mem_m_ack     = 1'b0;
        mem_m_data_in = '0;
        for (int p = 0; p < NP; p++) begin
            a_addr[p]  = AW'(32'h100 + p);
            a_wdata[p] = DW'(32'hA000 + p);
            a_bs[p]    = '1;
        end
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        m_owner  = -1;
        m_hp     = NP - 1;
        m_lp     = NP - 1;
        m_burst  = 0;
        m_cnt    = 0;
        m_in_ack = 1'b0;
    endtask

    // Class choice first, then the nearest requester after that class's pointer.
    task automatic model_pick(output int win);
        bit want_hi;
        int base;
        want_hi = (req_access & HI) != '0;
        base    = want_hi ? m_hp : m_lp;
        win     = -1;
        for (int k = 1; k <= NP; k++) begin
            int q;
            q = (base + k) % NP;
            if (win < 0 && req_access[q] && (HI[q] == want_hi)) win = q;
        end
        if (win >= 0) begin
            if (want_hi) m_hp = win;
            else         m_lp = win;
        end
    endtask

    task automatic new_req(input int p);
        a_addr[p]     = AW'($urandom);
        a_wdata[p]    = DW'($urandom);
        a_bs[p]       = BW'($urandom_range(1, 3));
        req_wr_en[p]  = ($urandom_range(0, 1) == 1);
        req_lock[p]   = ($urandom_range(0, 2) == 0);
        req_access[p] = 1'b1;
    endtask

    task automatic raise_idle_ports();
        for (int p = 0; p < NP; p++) begin
            if (!req_access[p] && $urandom_range(0, 3) == 0) new_req(p);
        end
    endtask

    task automatic rnd_step();
        int  o;
        bit  hi_wait;
        mem_m_ack = 1'b0;
        if (m_in_ack) begin
            o = m_owner;
            check("rnd_ack", 32'(rsp_ack), 32'(1 << o));
            if (!req_wr_en[o]) check("rnd_rdata", 32'(rsp_rdata), 32'(rd_pattern(a_addr[o])));
            if ($urandom_range(0, 1) == 1) begin
                new_req(o);
            end else begin
                req_access[o] = 1'b0;
                req_lock[o]   = 1'b0;
            end
            raise_idle_ports();
            m_in_ack = 1'b0;
            hi_wait  = (req_access & HI) != '0;
            if (!(req_lock[o] && req_access[o] && m_burst < MB && !(hi_wait && !HI[o]))) begin
                m_burst = 0;
                model_pick(m_owner);
            end
            m_cnt = $urandom_range(0, 3);
        end else if (m_owner < 0) begin
            check("rnd_idle_access", 32'(mem_m_access), 32'd0);
            check("rnd_idle_addr", 32'(mem_m_addr), 32'd0);
            check("rnd_idle_ack", 32'(rsp_ack), 32'd0);
            raise_idle_ports();
            model_pick(m_owner);
            m_cnt = $urandom_range(0, 3);
        end else begin
            o = m_owner;
            check("rnd_grant", 32'(grant_id), 32'(o));
            check("rnd_access", 32'(mem_m_access), 32'd1);
            check("rnd_addr", 32'(mem_m_addr), 32'(a_addr[o]));
            check("rnd_wr_en", 32'(mem_m_wr_en), 32'(req_wr_en[o]));
            check("rnd_bytesel", 32'(mem_m_bytesel), 32'(a_bs[o]));
            check("rnd_no_ack", 32'(rsp_ack), 32'd0);
            if (req_wr_en[o]) check("rnd_wdata", 32'(mem_m_data_out), 32'(a_wdata[o]));
            if (m_cnt == 0) begin
                mem_m_ack     = 1'b1;
                mem_m_data_in = rd_pattern(a_addr[o]);
                m_in_ack      = 1'b1;
                if (m_burst < MB) m_burst++;
            end else begin
                m_cnt--;
            end
            raise_idle_ports();
        end
    endtask

    typedef struct {
        logic [NP-1:0] mask;
        logic          exp_valid;
        int            exp_id;
    } first_vec_t;

    first_vec_t tbl [8];
    int         order [$];
    int         exp_rr [6];
    int         n0;
    bit         seen1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("reset_grant_valid", 32'(grant_valid), 32'd0);
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_rsp_ack", 32'(rsp_ack), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_bytesel", 32'(mem_m_bytesel), 32'h3);

        // First grant out of reset for a given request mask.
        tbl[0] = '{4'b0001, 1'b1, 0};
        tbl[1] = '{4'b0010, 1'b1, 1};
        tbl[2] = '{4'b1000, 1'b1, 3};
        tbl[3] = '{4'b1010, 1'b1, 1};
        tbl[4] = '{4'b0100, 1'b1, 2};
        tbl[5] = '{4'b1111, 1'b1, 2};
        tbl[6] = '{4'b0110, 1'b1, 2};
        tbl[7] = '{4'b0000, 1'b0, 0};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req_access = tbl[i].mask;
            @(negedge clk);
            check("tbl_valid", 32'(grant_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check("tbl_grant", 32'(grant_id), 32'(tbl[i].exp_id));
                check("tbl_addr", 32'(mem_m_addr), 32'(a_addr[tbl[i].exp_id]));
                check("tbl_access", 32'(mem_m_access), 32'd1);
            end else begin
                check("tbl_idle_access", 32'(mem_m_access), 32'd0);
                check("tbl_idle_bytesel", 32'(mem_m_bytesel), 32'h3);
            end
            req_access = '0;
        end

        // Single read, memory acks on the second SERVE cycle.
        do_reset();
        a_addr[0]  = 19'h00100;
        req_access = 4'b0001;
        check("t1_c0_access", 32'(mem_m_access), 32'd0);
        @(negedge clk);
        check("t1_c1_access", 32'(mem_m_access), 32'd1);
        check("t1_c1_addr", 32'(mem_m_addr), 32'h100);
        @(negedge clk);
        check("t1_c2_access", 32'(mem_m_access), 32'd1);
        mem_m_ack     = 1'b1;
        mem_m_data_in = 16'hBEEF;
        @(negedge clk);
        check("t1_ack", 32'(rsp_ack), 32'h1);
        check("t1_rdata", 32'(rsp_rdata), 32'hBEEF);
        check("t1_ack_cycle_access", 32'(mem_m_access), 32'd0);
        mem_m_ack  = 1'b0;
        req_access = '0;
        @(negedge clk);
        check("t1_ack_gone", 32'(rsp_ack), 32'd0);
        check("t1_idle_valid", 32'(grant_valid), 32'd0);
        check("t1_rdata_held", 32'(rsp_rdata), 32'hBEEF);

        // Low-class round robin over ports 0, 1, 3.
        do_reset();
        req_access = 4'b1011;
        order.delete();
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(negedge clk);
            if (mem_m_access) begin
                order.push_back(int'(grant_id));
                mem_m_ack = 1'b1;
            end else begin
                mem_m_ack = 1'b0;
            end
        end
        mem_m_ack = 1'b0;
        exp_rr = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < 6; i++) begin
            check("t2_rr_order", 32'((order.size() > i) ? order[i] : -1), 32'(exp_rr[i]));
        end

        // High-class port waits for the in-flight locked word.
        do_reset();
        req_access = 4'b0010;
        req_lock   = 4'b0010;
        @(negedge clk);
        check("t3_owner1", 32'(grant_id), 32'd1);
        req_access[2] = 1'b1;
        @(negedge clk);
        check("t3_no_preempt", 32'(grant_id), 32'd1);
        check("t3_no_preempt_addr", 32'(mem_m_addr), 32'(a_addr[1]));
        mem_m_ack     = 1'b1;
        mem_m_data_in = 16'h1111;
        @(negedge clk);
        check("t3_ack1", 32'(rsp_ack), 32'h2);
        mem_m_ack = 1'b0;
        @(negedge clk);
        check("t3_hi_wins", 32'(grant_id), 32'd2);
        check("t3_hi_addr", 32'(mem_m_addr), 32'(a_addr[2]));

        // Locked burst bounded at MAX_BURST words.
        do_reset();
        req_access = 4'b0011;
        req_lock   = 4'b0001;
        n0    = 0;
        seen1 = 1'b0;
        for (int c = 0; c < 60 && !seen1; c++) begin
            @(negedge clk);
            mem_m_ack = mem_m_access;
            if (rsp_ack == 4'b0001) n0++;
            if (rsp_ack == 4'b0010) seen1 = 1'b1;
        end
        mem_m_ack = 1'b0;
        check("t4_burst_len", 32'(n0), 32'(MB));
        check("t4_port1_acked", 32'(seen1), 32'd1);

        // Owner drops its request mid-word: same-cycle re-pick.
        do_reset();
        req_access = 4'b1000;
        @(negedge clk);
        check("t5_owner3", 32'(grant_id), 32'd3);
        req_access[0] = 1'b1;
        @(negedge clk);
        req_access[3] = 1'b0;
        #1;
        check("t5_access_drop", 32'(mem_m_access), 32'd0);
        @(negedge clk);
        check("t5_owner0", 32'(grant_id), 32'd0);
        check("t5_addr0", 32'(mem_m_addr), 32'(a_addr[0]));
        check("t5_no_ack3", 32'(rsp_ack), 32'd0);

        // Asynchronous reset mid-SERVE, then RR restart.
        do_reset();
        req_access = 4'b0010;
        @(negedge clk);
        check("t6_owner1", 32'(grant_id), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_access", 32'(mem_m_access), 32'd0);
        check("t6_async_valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        req_access = 4'b1011;
        @(negedge clk);
        check("t6_rr_restart", 32'(grant_id), 32'd0);
        mem_m_ack     = 1'b1;
        mem_m_data_in = 16'h2222;
        @(negedge clk);
        mem_m_ack = 1'b0;
        check("t6_ack_before_reset", 32'(rsp_ack), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_ack", 32'(rsp_ack), 32'd0);
        check("t6_async_rdata", 32'(rsp_rdata), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rnd_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
